// File: rtl/booth_iter_seq.sv
// Iterative radix-4 Booth multiplier sequencer: drives a shared external Booth
// encoder for LENGTH/2 cycles and accumulates the shifted signed partial products.
module booth_iter_seq #(
   parameter int LENGTH = 32,
   parameter int CNT_W  = $clog2(LENGTH/2)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clear_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [LENGTH-1:0]     a_i,
   input  logic [LENGTH-1:0]     b_i,
   output logic [LENGTH-1:0]     pp_a_o,
   output logic [2:0]            pp_sel_o,
   input  logic [LENGTH+1:0]     pp_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [2*LENGTH-1:0]   p_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(LENGTH/2 - 1);

   state_t                state_q;
   logic [CNT_W-1:0]      k_q;
   logic [LENGTH-1:0]     a_q;
   logic [LENGTH-1:0]     b_q;
   logic [2*LENGTH-1:0]   acc_q;

   logic [LENGTH:0]       b_ext;
   logic [2*LENGTH-1:0]   pp_ext;

   // Appending a zero supplies the implicit B[-1]=0 for the first triplet.
   assign b_ext  = {b_q, 1'b0};
   assign pp_ext = {{(LENGTH-2){pp_i[LENGTH+1]}}, pp_i};

   assign pp_a_o      = a_q;
   assign pp_sel_o    = (state_q == BUSY) ? b_ext[{k_q, 1'b0} +: 3] : 3'b000;
   assign in_ready_o  = rst_n_i && (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign p_o         = (state_q == DONE) ? acc_q : '0;
   assign busy_o      = (state_q != IDLE);

   // NOTE: all state lives in this one clocked block with non-blocking assignments,
   // so every register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
      end else if (clear_i) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  acc_q   <= '0;
                  k_q     <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // Partial product k carries weight 4^k, i.e. a shift of 2k.
               acc_q <= acc_q + (pp_ext << {k_q, 1'b0});
               k_q   <= k_q + 1'b1;
               if (k_q == K_LAST) state_q <= DONE;
            end
            DONE: begin
               if (out_ready_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_iter_seq.sv
// Directed bench for booth_iter_seq at LENGTH=8 and LENGTH=32, each DUT paired
// with a behavioural Booth encoder.
module tb_booth_iter_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- LENGTH = 8 ----------------
   logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, busy8;
   logic [7:0]  a8 = '0, b8 = '0, pa8;
   logic [2:0]  sel8;
   logic [9:0]  pp8, pa8_ext;
   logic [15:0] p8;

   assign pa8_ext = {{2{pa8[7]}}, pa8};
   always_comb begin
      pp8 = '0;
      case (sel8)
         3'b001, 3'b010: pp8 = pa8_ext;
         3'b011:         pp8 = pa8_ext << 1;
         3'b100:         pp8 = -(pa8_ext << 1);
         3'b101, 3'b110: pp8 = -pa8_ext;
         default:        pp8 = '0;
      endcase
   end

   booth_iter_seq #(.LENGTH(8)) dut8 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
      .in_valid_i(in_valid8), .in_ready_o(in_ready8), .a_i(a8), .b_i(b8),
      .pp_a_o(pa8), .pp_sel_o(sel8), .pp_i(pp8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready8), .p_o(p8), .busy_o(busy8)
   );

   // ---------------- LENGTH = 32 ----------------
   logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_ready32 = 1'b0, busy32;
   logic [31:0] a32 = '0, b32 = '0, pa32;
   logic [2:0]  sel32;
   logic [33:0] pp32, pa32_ext;
   logic [63:0] p32;

   assign pa32_ext = {{2{pa32[31]}}, pa32};
   always_comb begin
      pp32 = '0;
      case (sel32)
         3'b001, 3'b010: pp32 = pa32_ext;
         3'b011:         pp32 = pa32_ext << 1;
         3'b100:         pp32 = -(pa32_ext << 1);
         3'b101, 3'b110: pp32 = -pa32_ext;
         default:        pp32 = '0;
      endcase
   end

   booth_iter_seq #(.LENGTH(32)) dut32 (
      .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear),
      .in_valid_i(in_valid32), .in_ready_o(in_ready32), .a_i(a32), .b_i(b32),
      .pp_a_o(pa32), .pp_sel_o(sel32), .pp_i(pp32),
      .out_valid_o(out_valid32), .out_ready_i(out_ready32), .p_o(p32), .busy_o(busy32)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One LENGTH=8 transaction with a DONE stall of 'stall' cycles.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall,
                       input logic [15:0] exp);
      int n;
      check("run8_in_ready", in_ready8, 1'b1);
      in_valid8 = 1'b1; a8 = a; b8 = b; out_ready8 = 1'b0;
      tick();
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 50) begin tick(); n++; end
      check("run8_latency", n, 4);
      check("run8_p", p8, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("run8_stall_p", p8, exp);
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check("run8_one_handshake", out_valid8, 1'b0);
   endtask

   task automatic run32(input logic [31:0] a, input logic [31:0] b, input int stall,
                        input logic [63:0] exp);
      int n;
      check("run32_in_ready", in_ready32, 1'b1);
      in_valid32 = 1'b1; a32 = a; b32 = b; out_ready32 = 1'b0;
      tick();
      in_valid32 = 1'b0;
      n = 0;
      while (!out_valid32 && n < 100) begin tick(); n++; end
      check("run32_latency", n, 16);
      check("run32_p", p32, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("run32_stall_p", p32, exp);
      end
      out_ready32 = 1'b1;
      tick();
      out_ready32 = 1'b0;
      check("run32_one_handshake", out_valid32, 1'b0);
   endtask

   initial begin
      logic [2:0]  exp_sel [4];
      logic signed [7:0]  ra8, rb8;
      logic signed [15:0] rp8;
      logic signed [31:0] ra32, rb32;
      logic signed [63:0] rp32;

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      check("rst_in_ready_low", in_ready8, 1'b0);
      check("rst_out_valid", out_valid8, 1'b0);
      check("rst_p", p8, 16'h0);
      check("rst_busy", busy8, 1'b0);
      check("rst_sel", sel8, 3'b000);
      check("rst_pp_a", pa8, 8'h0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready_rel", in_ready8, 1'b1);
      check("rst_in_ready_rel32", in_ready32, 1'b1);

      // 3 * 5 with out_ready held high: Booth triplets and latency
      exp_sel = '{3'b010, 3'b010, 3'b000, 3'b000};
      out_ready8 = 1'b1; in_valid8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
      tick();
      in_valid8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("d1_sel", sel8, exp_sel[i]);
         check("d1_busy", busy8, 1'b1);
         check("d1_no_valid", out_valid8, 1'b0);
         tick();
      end
      check("d1_valid", out_valid8, 1'b1);
      check("d1_p", p8, 16'h000F);
      check("d1_pp_a", pa8, 8'd3);
      check("d1_ready_done", in_ready8, 1'b0);
      check("d1_sel_done", sel8, 3'b000);
      tick();
      out_ready8 = 1'b0;
      check("d1_idle_valid", out_valid8, 1'b0);
      check("d1_idle_ready", in_ready8, 1'b1);

      // Extreme operands
      run8(8'h80, 8'h80, 0, 16'h4000);
      run8(8'd127, 8'h80, 1, 16'hC080);

      // Back-pressure in DONE with new operands offered
      in_valid8 = 1'b1; a8 = 8'd10; b8 = 8'hFD;
      tick();
      a8 = 8'd99; b8 = 8'd77;
      repeat (4) tick();
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", out_valid8, 1'b1);
         check("bp_p", p8, 16'hFFE2);
         check("bp_ready", in_ready8, 1'b0);
         check("bp_pp_a", pa8, 8'd10);
         tick();
      end
      in_valid8 = 1'b0; out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check("bp_release_valid", out_valid8, 1'b0);
      check("bp_release_ready", in_ready8, 1'b1);
      run8(8'd5, 8'd6, 0, 16'h001E);

      // clear_i at BUSY step 2 alongside in_valid_i
      in_valid8 = 1'b1; a8 = 8'd50; b8 = 8'd50;
      tick();
      in_valid8 = 1'b0;
      tick(); tick();
      clear = 1'b1; in_valid8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      tick();
      clear = 1'b0; in_valid8 = 1'b0;
      check("clr_busy", busy8, 1'b0);
      check("clr_valid", out_valid8, 1'b0);
      check("clr_ready", in_ready8, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("clr_no_output", out_valid8, 1'b0);
      end
      run8(8'hF9, 8'd9, 0, 16'hFFC1);

      // Reset while DONE
      in_valid8 = 1'b1; a8 = 8'd2; b8 = 8'd3;
      tick();
      in_valid8 = 1'b0;
      repeat (4) tick();
      check("rd_valid_before", out_valid8, 1'b1);
      check("rd_p_before", p8, 16'h0006);
      rst_n = 1'b0;
      tick();
      check("rd_valid", out_valid8, 1'b0);
      check("rd_p", p8, 16'h0);
      check("rd_ready_low", in_ready8, 1'b0);
      check("rd_busy", busy8, 1'b0);
      rst_n = 1'b1;
      #1;
      check("rd_ready_rel", in_ready8, 1'b1);

      // 32-bit directed corner cases
      run32(32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000);
      run32(32'h7FFF_FFFF, 32'h8000_0000, 2, 64'hC000_0000_8000_0000);
      run32(32'hFFFF_FFFF, 32'd12345, 0, 64'hFFFF_FFFF_FFFF_CFC7);

      // Random sweeps against the golden signed product
      for (int i = 0; i < 400; i++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom);
         rp8 = ra8 * rb8;
         repeat ($urandom_range(0, 2)) tick();
         run8(ra8, rb8, $urandom_range(0, 3), rp8);
      end
      for (int i = 0; i < 300; i++) begin
         ra32 = $urandom; rb32 = $urandom;
         rp32 = ra32 * rb32;
         repeat ($urandom_range(0, 2)) tick();
         run32(ra32, rb32, $urandom_range(0, 3), rp32);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
